gpio_host_initiator: RTL
========================

Name: gpio_host_initiator

Overview:
- Host-side initiator for the FPGA–Raspberry Pi parallel GPIO link: the far end of the link that the parallel interface block responds to.
- Generates the external clock (xclk) and chip select (cs). Drives a BURST_SIZE-byte write burst onto the data bus, or releases the bus and captures a BURST_SIZE-byte read burst.
- Uses: bus-functional initiator in the FPGA-to-FPGA loopback build, and link driver when a second DE0 replaces the Pi.
- Tristate buffers are instantiated at the top level; this block exposes separate data_out, data_oe and data_in.

Parameters:
- BURST_SIZE, 8, bytes per transaction.
- DATA_WIDTH, 8, data bus width.
- CLK_DIV, 2, clk cycles per xclk half-period. Must be ≥ 2.

Ports:
- clk  in  1  system clock (50 MHz). All logic is on the rising edge.
- rst  in  1  synchronous reset, active-high.
- wr_en  in  1  push wr_data into the TX buffer.
- wr_data  in  DATA_WIDTH  byte to be sent.
- tx_full  out  1  TX buffer holds BURST_SIZE bytes.
- start  in  1  single-cycle request to begin a transaction.
- dir  in  1  transaction direction: 0 = write (host→device), 1 = read. Sampled with start.
- busy  out  1  transaction in progress.
- done  out  1  one-cycle pulse at transaction end.
- rd_valid  out  1  one-cycle pulse: rd_data holds a captured byte.
- rd_data  out  DATA_WIDTH  captured read byte.
- xclk  out  1  link clock to the device.
- cs  out  1  link chip select, active-high ("load").
- data_out  out  DATA_WIDTH  bus drive value.
- data_oe  out  1  bus output enable.
- data_in  in  DATA_WIDTH  bus pin value.

Behaviour:
- Reset (synchronous, active-high) takes effect at the next clk edge, including mid-transaction:
  - xclk=0, cs=0, data_oe=0, data_out=0.
  - busy=0, done=0, rd_valid=0, rd_data=0.
  - TX write pointer cleared (tx_full=0). State returns to IDLE.
- TX buffer: BURST_SIZE×DATA_WIDTH storage.
  - wr_en while !busy && !tx_full stores wr_data at the pointer and increments it.
  - wr_en while busy or tx_full is ignored.
  - Pointer clears when a write transaction completes.
- Start acceptance:
  - start accepted only in IDLE.
  - Write (dir=0) is accepted only if tx_full=1; otherwise start is ignored and busy stays 0.
  - start while busy is ignored.
- State machine: IDLE → SETUP → HIGH ↔ LOW → DONE → IDLE.
  - A half-phase counter (0..CLK_DIV-1) times each phase. A byte counter of width $clog2(BURST_SIZE)+1 counts bytes.
  - SETUP (entered on the edge after start is accepted):
    - cs=1, xclk=0, busy=1.
    - Write: data_oe=1, data_out=byte0, duration CLK_DIV cycles.
    - Read: data_oe=0, duration 2×CLK_DIV cycles (turnaround).
  - HIGH: xclk=1 for CLK_DIV cycles. The device samples data on the xclk rising edge.
  - LOW: xclk=0 for CLK_DIV cycles.
    - Write: data_out advances to the next byte on entry. After the last byte it holds the last byte.
    - After the BURST_SIZE-th LOW, go to DONE.
  - DONE (one cycle):
    - cs=0, data_oe=0, busy=0, done=1.
    - TX pointer clears if the transaction was a write.
    - Next cycle: IDLE.
- Transaction length from start-accept edge to the cs falling edge:
  - Write: CLK_DIV + 2×CLK_DIV×BURST_SIZE cycles.
  - Read: 2×CLK_DIV + 2×CLK_DIV×BURST_SIZE cycles.
- Read capture:
  - data_in is registered once (din_q).
  - din_q is sampled on the last clk cycle of each HIGH phase.
  - rd_valid pulses with rd_data on the following cycle, BURST_SIZE pulses per read.
- xclk, cs, data_out and data_oe are registered outputs (glitch-free).
- data_oe never asserts while dir=1, and never outside cs=1.

Test Plan:
- Reset then idle: rst=1 for 2 cycles → all outputs 0; start with dir=0 and empty buffer → busy stays 0, no xclk activity.
- Write burst, CLK_DIV=2: push 0x11,0x22…0x88 (tx_full=1 after 8th), start dir=0 → exactly 8 xclk rising edges; data_out on rising edge n = 0x11×n; cs high 34 cycles; done 1 cycle; tx_full=0 afterwards.
- Read burst: device model drives 0xA0+n on each xclk falling edge; start dir=1 → data_oe stays 0; cs high 36 cycles; 8 rd_valid pulses with rd_data 0xA0…0xA7.
- Ignored requests: wr_en and start mid-burst, plus a 9th wr_en when full → no buffer change, current burst unaffected, no second transaction.
- Reset mid-write after 3 xclk rising edges → next cycle cs=0, xclk=0, data_oe=0, tx_full=0; a new full write then runs normally.
- Back-to-back: start asserted the cycle after done → accepted, new SETUP begins the following cycle; CLK_DIV=5 variant gives 10-cycle xclk period.

Source files
------------

// File: rtl/gpio_host_initiator_if.sv
// Purpose : link-side signal bundle between the GPIO host initiator and the
//           parallel interface device (clock, chip select, data bus halves).
// Ports   : master = initiator (drives xclk/cs/data_out/data_oe, reads data_in),
//           slave  = device side / bus model (the mirror image).
// Timing  : pure wiring, no latency; no flow control on the link itself.
interface gpio_host_initiator_if #(
  parameter int DATA_WIDTH = 8
);

  logic                  xclk;      // link clock to the device
  logic                  cs;        // chip select, active-high
  logic [DATA_WIDTH-1:0] data_out;  // value driven onto the bus when data_oe=1
  logic                  data_oe;   // bus output enable (tristate control at top)
  logic [DATA_WIDTH-1:0] data_in;   // value seen on the bus pins

  modport master (
    output xclk,
    output cs,
    output data_out,
    output data_oe,
    input  data_in
  );

  modport slave (
    input  xclk,
    input  cs,
    input  data_out,
    input  data_oe,
    output data_in
  );

endinterface

// File: rtl/gpio_host_initiator.sv
// Purpose : host-side initiator of the parallel GPIO link; generates xclk/cs and
//           runs one BURST_SIZE-byte write or read burst per accepted start.
// Latency : cs rises one clk after start is accepted; write burst is
//           CLK_DIV + 2*CLK_DIV*BURST_SIZE cycles, read adds one extra CLK_DIV
//           of bus turnaround; read bytes appear one cycle after each HIGH phase.
// Backpr. : start is dropped unless IDLE (and, for writes, the TX buffer is full);
//           wr_en is dropped while busy or tx_full. No stalling once a burst runs.
// Ports   : clk/rst (sync, active-high); wr_en/wr_data/tx_full fill the TX buffer;
//           start/dir launch a burst; busy/done report progress; rd_valid/rd_data
//           return captured read bytes; link (master modport) is the device bus.
module gpio_host_initiator #(
  parameter int BURST_SIZE = 8,
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  tx_full,
  input  logic                  start,
  input  logic                  dir,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  gpio_host_initiator_if.master link
);

  // Byte pointer/counter must be able to hold BURST_SIZE itself.
  localparam int PW = $clog2(BURST_SIZE) + 1;
  localparam int IW = (BURST_SIZE > 1) ? $clog2(BURST_SIZE) : 1;
  // Phase counter must reach 2*CLK_DIV-1 for the read turnaround in SETUP.
  localparam int CW = $clog2(2 * CLK_DIV);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    HIGH,
    LOW,
    DONE
  } state_t;

  state_t state;
  state_t state_n;

  // TX buffer and its fill pointer
  logic [DATA_WIDTH-1:0] tx_buf [BURST_SIZE];
  logic [PW-1:0]         wr_ptr;
  logic                  push;

  // Sequencing
  logic [CW-1:0] ph_cnt;
  logic [CW-1:0] ph_lim;
  logic          ph_last;
  logic          hi_end;
  logic [PW-1:0] byte_cnt;
  logic [PW-1:0] byte_nxt;
  logic          rd_mode;
  logic          mode_n;
  logic          accept;
  logic          active_n;

  // Registered outputs
  logic                  xclk_q;
  logic                  cs_q;
  logic                  oe_q;
  logic [DATA_WIDTH-1:0] dout_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  rd_valid_q;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic [DATA_WIDTH-1:0] din_q;

  assign tx_full  = (wr_ptr == PW'(BURST_SIZE));
  assign push     = wr_en && !busy_q && !tx_full;
  assign byte_nxt = byte_cnt + 1'b1;

  assign busy          = busy_q;
  assign done          = done_q;
  assign rd_valid      = rd_valid_q;
  assign rd_data       = rd_data_q;
  assign link.xclk     = xclk_q;
  assign link.cs       = cs_q;
  assign link.data_oe  = oe_q;
  assign link.data_out = dout_q;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_n = state;
    accept  = 1'b0;
    // Read SETUP is twice as long: gives the device time to turn the bus around.
    ph_lim  = (state == SETUP && rd_mode) ? CW'(2 * CLK_DIV - 1) : CW'(CLK_DIV - 1);
    ph_last = (ph_cnt == ph_lim);
    hi_end  = (state == HIGH) && ph_last;

    case (state)
      IDLE: begin
        // A write needs a complete burst already staged in the buffer.
        if (start && (dir || tx_full)) begin
          accept  = 1'b1;
          state_n = SETUP;
        end
      end
      SETUP: begin
        if (ph_last) state_n = HIGH;
      end
      HIGH: begin
        if (ph_last) state_n = LOW;
      end
      LOW: begin
        // byte_cnt counts completed HIGH phases, so it equals BURST_SIZE here
        // only during the final LOW.
        if (ph_last) begin
          state_n = (byte_cnt == PW'(BURST_SIZE)) ? DONE : HIGH;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    mode_n   = accept ? dir : rd_mode;
    active_n = (state_n == SETUP) || (state_n == HIGH) || (state_n == LOW);
  end

  // ---------------------------------------------------------------------------
  // TX buffer storage (contents need no reset; the pointer guards them)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (push) begin
      tx_buf[wr_ptr[IW-1:0]] <= wr_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Counters, datapath and registered outputs. Link outputs are computed from
  // the next state so they change exactly on the state-change edge.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      ph_cnt     <= '0;
      byte_cnt   <= '0;
      rd_mode    <= 1'b0;
      xclk_q     <= 1'b0;
      cs_q       <= 1'b0;
      oe_q       <= 1'b0;
      dout_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      din_q      <= '0;
    end else begin
      // TX pointer: a finished write frees the whole buffer.
      if (state == DONE && !rd_mode) begin
        wr_ptr <= '0;
      end else if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end

      // Phase timer restarts on every state change.
      if (state_n != state || state == IDLE) begin
        ph_cnt <= '0;
      end else begin
        ph_cnt <= ph_cnt + 1'b1;
      end

      if (accept) begin
        byte_cnt <= '0;
      end else if (hi_end) begin
        byte_cnt <= byte_nxt;
      end

      rd_mode <= mode_n;

      xclk_q <= (state_n == HIGH);
      cs_q   <= active_n;
      busy_q <= active_n;
      done_q <= (state_n == DONE);
      // Never drive the bus during a read or outside chip select.
      oe_q   <= active_n && !mode_n;

      // Byte 0 is presented in SETUP; later bytes on entry to LOW, i.e. right
      // after the device has sampled the current one. Last byte is held.
      if (accept && !dir) begin
        dout_q <= tx_buf[0];
      end else if (hi_end && !rd_mode && (byte_nxt < PW'(BURST_SIZE))) begin
        dout_q <= tx_buf[byte_nxt[IW-1:0]];
      end

      // Single register stage on the pin value; the sample taken on the last
      // cycle of HIGH is the value the device set up during the previous LOW.
      din_q      <= link.data_in;
      rd_valid_q <= hi_end && rd_mode;
      if (hi_end && rd_mode) begin
        rd_data_q <= din_q;
      end
    end
  end

endmodule
